// File: rtl/wb_host_pkg.sv
// Shared types for the Wishbone host master: FSM state encoding and the command FIFO word.
package wb_host_pkg;

    localparam int unsigned WB_AW  = 32;
    localparam int unsigned WB_DW  = 32;
    localparam int unsigned WB_SW  = WB_DW / 8;
    localparam int unsigned TMO_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
    } cmd_t;

endpackage

// File: rtl/wb_host_cmd_fifo.sv
// Synchronous command FIFO; ready/empty flags are registered from the next count.
module wb_host_cmd_fifo
    import wb_host_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  cmd_t                   wdata_i,
    input  logic                   pop_i,
    output cmd_t                   head_c,
    output logic                   ready_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ready_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign ready_o = ready_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: FIFO-buffered commands, one bus cycle at a time, ack timeout.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned AW          = WB_AW,
    parameter int unsigned DW          = WB_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i,
    output logic            busy
);

    localparam int unsigned SW       = DW / 8;
    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TMO_LAST = TIMEOUT_CYC - 1;

    cmd_t          push_word;
    cmd_t          head;
    logic          push;
    logic          pop;
    logic          fifo_ready;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;

    state_e           state_q,     state_d;
    logic [TMO_W-1:0] tmo_q,       tmo_d;
    logic             cyc_q,       cyc_d;
    logic             we_q,        we_d;
    logic [SW-1:0]    sel_q,       sel_d;
    logic [AW-1:0]    adr_q,       adr_d;
    logic [DW-1:0]    dat_q,       dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [DW-1:0]    rsp_dat_q,   rsp_dat_d;
    logic             busy_q,      busy_d;

    assign push = cmd_valid && fifo_ready;

    always_comb begin
        push_word     = '0;
        push_word.we  = cmd_we;
        push_word.adr = WB_AW'(cmd_adr);
        push_word.dat = WB_DW'(cmd_dat);
        push_word.sel = WB_SW'(cmd_sel);
    end

    wb_host_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .head_c  (head),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state and output logic; ack wins over the timeout on the final cycle.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    we_d    = head.we;
                    adr_d   = AW'(head.adr);
                    dat_d   = DW'(head.dat);
                    sel_d   = SW'(head.sel);
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (tmo_q == TMO_W'(TMO_LAST)) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // busy is registered against the post-edge FIFO occupancy so it tracks exactly.
    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign busy_d     = (count_next != '0) || (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = fifo_ready;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: vector table plus FIFO, reset and ack corner sequences.
module tb_wb_host_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_host_master #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (8),
        .AW          (32),
        .DW          (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: acks after slave_wait wait states; derive mode returns address-based data.
    logic        slave_en     = 1'b1;
    logic        force_ack    = 1'b0;
    logic        slave_derive = 1'b0;
    int          slave_wait   = 0;
    logic [31:0] slave_rdata  = 32'h0;
    int          wcnt         = 0;

    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
    end

    always @(negedge clk) begin
        if (!slave_en) begin
            wbm_ack_i = force_ack;
            wbm_dat_i = 32'h5555_AAAA;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (wcnt == slave_wait) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = slave_derive ? (wbm_adr_o ^ 32'hA5A5_0000) : slave_rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wcnt      = wcnt + 1;
            end
        end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'h0BAD_0BAD;
            wcnt      = 0;
        end
    end

    int   bus_cycles = 0;
    logic cyc_prev   = 1'b0;
    always @(negedge clk) begin
        if (wbm_cyc_o && !cyc_prev) bus_cycles = bus_cycles + 1;
        cyc_prev = wbm_cyc_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          wt;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   issue;
        int   cyc_n;
        logic got;
        logic stable_ok;
        logic [31:0] held;
        issue     = 0;
        cyc_n     = 0;
        got       = 1'b0;
        stable_ok = 1'b1;
        slave_wait  = v.wt;
        slave_rdata = v.rdata;
        chk($sformatf("v%0d_ready", idx), 32'(cmd_ready), 32'd1);
        push_cmd(v.we, v.adr, v.dat, v.sel);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (wbm_cyc_o) begin
                if (cyc_n == 0) begin
                    chk($sformatf("v%0d_adr", idx), wbm_adr_o, v.adr);
                    chk($sformatf("v%0d_we", idx), 32'(wbm_we_o), 32'(v.we));
                    chk($sformatf("v%0d_sel", idx), 32'(wbm_sel_o), 32'(v.sel));
                    if (v.we) chk($sformatf("v%0d_dato", idx), wbm_dat_o, v.dat);
                end
                if (wbm_adr_o !== v.adr || wbm_we_o !== v.we || wbm_sel_o !== v.sel ||
                    wbm_stb_o !== 1'b1)
                    stable_ok = 1'b0;
                cyc_n++;
            end else if (cyc_n == 0) begin
                issue++;
            end
        end
        chk($sformatf("v%0d_rsp_seen", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d_issue_lat", idx), 32'(issue), 32'd1);
        chk($sformatf("v%0d_cyc_len", idx), 32'(cyc_n), 32'(v.exp_cyc));
        chk($sformatf("v%0d_stable", idx), 32'(stable_ok), 32'd1);
        chk($sformatf("v%0d_cyc_drop", idx), 32'(wbm_cyc_o), 32'd0);
        chk($sformatf("v%0d_rsp_dat", idx), rsp_dat, v.exp_dat);
        chk($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        held = rsp_dat;
        @(negedge clk);
        chk($sformatf("v%0d_hold_valid", idx), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d_hold_dat", idx), rsp_dat, held);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_consumed", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        logic        seen;
        int          acc;
        int          k;
        int          n;
        int          bc0;
        logic        pend;
        logic [31:0] got_dat [6];

        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2,    32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 3};
        vecs[1] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 0,    32'h1234_5678, 1'b0, 32'h1234_5678, 1};
        vecs[2] = '{1'b0, 32'h3000_0020, 32'h0000_0000, 4'hF, 1000, 32'h7777_7777, 1'b1, 32'h0000_0000, 8};
        vecs[3] = '{1'b0, 32'h3000_0024, 32'h0000_0000, 4'hF, 0,    32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1};
        vecs[4] = '{1'b0, 32'h3000_0028, 32'h0000_0000, 4'hF, 7,    32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 8};
        vecs[5] = '{1'b1, 32'h3000_002C, 32'h0BAD_F00D, 4'h3, 6,    32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 7};
        vecs[6] = '{1'b1, 32'h3000_0030, 32'h1122_3344, 4'hC, 1000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 8};
        vecs[7] = '{1'b0, 32'h3000_0034, 32'h0000_0000, 4'h1, 1,    32'h00FF_00FF, 1'b0, 32'h00FF_00FF, 2};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dato", wbm_dat_o, 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Ack while idle must be ignored
        @(posedge clk);
        #1;
        slave_en  = 1'b0;
        force_ack = 1'b1;
        seen      = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (rsp_valid || wbm_cyc_o || busy) seen = 1'b1;
        end
        chk("idle_ack_ignored", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        slave_en  = 1'b1;

        // FIFO full with response stalled: one in flight, four buffered, sixth held off
        slave_derive = 1'b1;
        slave_wait   = 0;
        @(posedge clk);
        #1;
        bc0 = bus_cycles;
        push_cmd(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("full_first_rsp", 32'(seen), 32'd1);
        acc = 0;
        k   = 1;
        for (int t = 0; t < 20 && k < 6; t++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_we    = 1'b0;
            cmd_adr   = 32'h3000_0100 + 32'(4 * k);
            cmd_sel   = 4'hF;
            if (!cmd_ready) break;
            @(posedge clk);
            #1;
            acc++;
            k++;
        end
        chk("full_accepted", 32'(acc), 32'd4);
        repeat (5) @(negedge clk);
        chk("full_ready_low", 32'(cmd_ready), 32'd0);
        chk("full_rsp_held", 32'(rsp_valid), 32'd1);
        chk("full_rsp_dat0", rsp_dat, 32'h95A5_0100);
        chk("full_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("full_one_bus_cycle", 32'(bus_cycles - bc0), 32'd1);
        rsp_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 200 && n < 6; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got_dat[n] = rsp_dat;
                n++;
            end
            pend = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (pend) cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("full_rsp_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < n) chk($sformatf("full_order%0d", i), got_dat[i], 32'h95A5_0100 + 32'(4 * i));
        end
        repeat (2) @(negedge clk);
        chk("full_drained_busy", 32'(busy), 32'd0);
        chk("full_drained_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("full_total_bus_cycles", 32'(bus_cycles - bc0), 32'd6);
        slave_derive = 1'b0;

        // Reset in the middle of a bus cycle with a second command still queued
        slave_wait = 1000;
        push_cmd(1'b1, 32'h3000_0200, 32'h0102_0304, 4'hF);
        push_cmd(1'b0, 32'h3000_0204, 32'h0, 4'hF);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (wbm_cyc_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_cyc_seen", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("mid_async_stb", 32'(wbm_stb_o), 32'd0);
        chk("mid_async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_async_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (wbm_cyc_o || rsp_valid) seen = 1'b1;
        end
        chk("mid_no_replay", 32'(seen), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        slave_wait = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic (B4, non-pipelined) initiator that drives the neuron core's slave port: the other end of the neuron_core_256x256 wbs_* interface.
- Accepts read/write commands on a valid/ready stream, buffers them in a small FIFO, executes one bus cycle at a time and returns one response per command.
- Has a per-cycle ack timeout, so a hung slave produces an error response instead of a lockup.
- Sits in the user area between a command source (LA or IO bridge) and the neuron core.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 255, clk cycles to wait for wbm_ack_i before aborting; 1..65535.
- AW, 32, address width.
- DW, 32, data width; wbm_sel_o width is DW/8.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  AW  byte address.
- cmd_dat  in  DW  write data.
- cmd_sel  in  DW/8  byte enables.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_dat  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  DW/8  byte selects.
- wbm_adr_o  out  AW  address.
- wbm_dat_o  out  DW  write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  DW  slave read data.
- busy  out  1  FIFO non-empty, or state not IDLE.

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0, except cmd_ready, which is 1.
- FIFO emptied; state IDLE; timeout counter 0.

Command FIFO:
- A command is pushed when cmd_valid && cmd_ready.
- cmd_ready = !full, registered from the FIFO count.
- A push and a pop in the same cycle are both honoured; count is unchanged.

FSM states: IDLE, BUS, RESP.
- IDLE: when the FIFO is non-empty, pop the head. On that edge, load wbm_adr/dat/sel/we from the head, set cyc=stb=1, clear the timeout counter, go to BUS. Issue latency is 1 cycle from the first entry becoming visible in the FIFO.
- BUS: cyc, stb and the bus fields stay stable.
  - If wbm_ack_i is sampled high: drop cyc/stb on the same edge and go to RESP. Capture wbm_dat_i if read, else 0. Set rsp_err=0 and rsp_valid=1.
  - Else, if the counter equals TIMEOUT_CYC-1: drop cyc/stb, set rsp_dat=0, rsp_err=1, rsp_valid=1, go to RESP.
  - Otherwise increment the counter.
- RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid and return to IDLE; the next bus cycle starts no earlier than the following edge.
- No back-to-back bus cycles. Minimum spacing: 1 idle cycle with cyc=0 between transactions.

Boundary conditions:
- wbm_ack_i outside BUS is ignored.
- An ack arriving in the same cycle the counter hits its limit counts as success; ack has priority.
- The response is dropped only by rsp_ready; there is no response overwrite because one transaction is outstanding at a time.
- Reset mid-transaction drops cyc/stb immediately (asynchronously); pending commands are lost.
- With FIFO full and rsp_ready held low, cmd_ready stays 0 and nothing is lost.
- wbm_dat_o and wbm_sel_o hold their last values after a cycle; slaves must qualify them with stb.

Decomposition:
- Package wb_host_pkg holds:
  - the state enum (IDLE/BUS/RESP);
  - a cmd_t struct {we, adr, dat, sel} used as the FIFO word;
  - localparams for the default widths.
- One sub-module: wb_host_cmd_fifo, a synchronous FIFO of cmd_t with full/empty flags, DEPTH parameter and async active-low reset. The FSM and timeout stay in the top.

Test Plan:
- Single write: cmd_we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks after 2 cycles.
  -> wbm_* stable for 3 cycles, cyc drops on the ack edge, rsp_valid=1, rsp_err=0, rsp_dat=0.
- Single read: adr=0x3000_0010; slave returns 0x1234_5678 with ack after 0 wait states.
  -> rsp_dat=0x1234_5678, with 1 cycle from cyc rising to rsp_valid rising.
- Timeout: TIMEOUT_CYC=8, slave never acks.
  -> cyc is high for exactly 8 cycles, then rsp_err=1 and rsp_dat=0; the next command then executes normally.
- FIFO full / backpressure: FIFO_DEPTH=4, push 6 commands while rsp_ready=0.
  -> cmd_ready drops after 4 accepted pushes, only 1 bus cycle occurs, and all 6 complete in order once rsp_ready=1.
- Ack-at-limit: ack asserted on the last timeout cycle.
  -> rsp_err=0 and data captured.
- Reset mid-BUS: deassert rst_n while cyc=1.
  -> cyc/stb/rsp_valid go to 0 without waiting for a clk edge; cmd_ready=1 and busy=0 after release.
